priority_encoder8to3: RTL

PRIORITY_ENCODER8TO3 -- requirements
Module: priority_encoder8to3

---
 rtl/priority_encoder8to3_pkg.sv | 21 ++
 rtl/priority_encoder8to3_if.sv | 23 ++
 rtl/priority_encoder8to3_prio_sel8.sv | 26 ++
 rtl/priority_encoder8to3.sv | 91 +++++++++
 4 files changed

// File: rtl/priority_encoder8to3_pkg.sv
// Shared constants, state encoding and helpers for the 8-to-3 request
// priority encoder.
package priority_encoder8to3_pkg;

   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // A request collides when it lands on a bit that is already pending,
   // unless that very bit is being selected (and cleared) this cycle.
   function automatic logic drop_hit(input logic [N_REQ-1:0] req,
                                     input logic [N_REQ-1:0] pend,
                                     input logic [N_REQ-1:0] consumed);
      return |(req & pend & ~consumed);
   endfunction

endpackage

// File: rtl/priority_encoder8to3_if.sv
// Request/response bundle between the request source/consumer and the
// priority encoder. The encoder sits on the slave side.
interface priority_encoder8to3_if;
   import priority_encoder8to3_pkg::*;

   logic [N_REQ-1:0]  req;
   logic              out_ready;
   logic [CODE_W-1:0] code;
   logic              valid;
   logic [N_REQ-1:0]  pending;
   logic              dropped;

   modport master (
      output req, out_ready,
      input  code, valid, pending, dropped
   );

   modport slave (
      input  req, out_ready,
      output code, valid, pending, dropped
   );

endinterface

// File: rtl/priority_encoder8to3_prio_sel8.sv
// Combinational highest-index-first selector: reports whether any bit is
// set, the index of the highest set bit, and that bit as a one-hot mask.
module prio_sel8
   import priority_encoder8to3_pkg::*;
(
   input  logic [N_REQ-1:0]  merged,
   output logic              any,
   output logic [CODE_W-1:0] idx,
   output logic [N_REQ-1:0]  onehot
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      any    = |merged;
      idx    = '0;
      onehot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (merged[i]) begin
            idx       = CODE_W'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_encoder8to3.sv
// Priority encoder with request latching: requests accumulate in a pending
// set and are presented one code at a time, highest index first, under a
// valid/out_ready handshake. Every output comes straight from a flop.
module priority_encoder8to3
   import priority_encoder8to3_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   priority_encoder8to3_if.slave bus
);

   state_t            state;
   logic [CODE_W-1:0] code_q;
   logic              valid_q;
   logic [N_REQ-1:0]  pend_q;
   logic              drop_q;

   logic [N_REQ-1:0]  merged;
   logic              sel_any;
   logic [CODE_W-1:0] sel_idx;
   logic [N_REQ-1:0]  sel_oh;
   logic              load;
   logic [N_REQ-1:0]  consumed;

   // Everything latched so far plus whatever arrives this cycle.
   assign merged = pend_q | bus.req;

   prio_sel8 u_sel (
      .merged (merged),
      .any    (sel_any),
      .idx    (sel_idx),
      .onehot (sel_oh)
   );

   // A new code is taken whenever the output slot is free (idle) or is being
   // emptied by a handshake this cycle, and there is something to serve.
   always_comb begin
      load     = sel_any && ((state == IDLE) || bus.out_ready);
      consumed = load ? sel_oh : '0;
   end

   // State, code, pending set and collision pulse; async reset drops all work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         code_q  <= '0;
         valid_q <= 1'b0;
         pend_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= drop_hit(bus.req, pend_q, consumed);
         case (state)
            IDLE: begin
               if (load) begin
                  code_q  <= sel_idx;
                  pend_q  <= merged & ~sel_oh;
                  valid_q <= 1'b1;
                  state   <= PRESENT;
               end else begin
                  pend_q  <= '0;
               end
            end
            PRESENT: begin
               if (!bus.out_ready) begin
                  // Stalled: code is frozen, new arrivals (including the
                  // presented index itself) are remembered for later.
                  pend_q <= merged;
               end else if (load) begin
                  code_q <= sel_idx;
                  pend_q <= merged & ~sel_oh;
               end else begin
                  pend_q  <= '0;
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               pend_q  <= '0;
            end
         endcase
      end
   end

   assign bus.code    = code_q;
   assign bus.valid   = valid_q;
   assign bus.pending = pend_q;
   assign bus.dropped = drop_q;

endmodule
